id_ex_stage: RTL and testbench

- Pipeline register and operand-preparation stage directly upstream of the 32-bit ALU in the MIPS datapath.
- Each cycle it captures a decoded instruction, derives the ALU's 3-bit opcode from aluop/funct, and resolves the A and B operands.
- Operand resolution covers EX/MEM and MEM/WB forwarding and sign-extended immediate selection.
- Registered outputs drive the ALU's opcode, A and B inputs one cycle after capture, under stall/flush control from the hazard unit.

---
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register placed directly in front of the ALU. Each cycle it
// captures a decoded instruction, derives the 3-bit ALU opcode from
// aluop/funct, resolves operands A and B (EX/MEM and MEM/WB forwarding plus
// sign-extended immediate) and presents them registered one cycle later.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   stall, flush           hazard-unit control (flush wins over stall)
//   in_valid               incoming instruction is valid
//   aluop, funct           main-decoder ALU class and R-type function field
//   alusrc                 1 = operand B takes the sign-extended immediate
//   rs_addr/rt_addr        source register indices
//   rs_data/rt_data        register-file read values
//   imm16                  instruction immediate
//   exmem_*                EX/MEM regwrite, destination and ALU result
//   memwb_*                MEM/WB regwrite, destination and writeback value
//   out_valid              registered outputs hold a valid instruction
//   alu_opcode/alu_a/alu_b registered ALU inputs
//   store_data             forwarded rt value for stores
//   illegal                unsupported aluop/funct combination captured
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [1:0]            aluop,
  input  logic [5:0]            funct,
  input  logic                  alusrc,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [WIDTH-1:0]      rs_data,
  input  logic [WIDTH-1:0]      rt_data,
  input  logic [15:0]           imm16,
  input  logic                  exmem_regwrite,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WIDTH-1:0]      exmem_res,
  input  logic                  memwb_regwrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WIDTH-1:0]      memwb_res,
  output logic                  out_valid,
  output logic [2:0]            alu_opcode,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [WIDTH-1:0]      store_data,
  output logic                  illegal
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [2:0]       op_next;
  logic             illegal_next;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] b_next;

  // Unsupported combinations still issue as an add so the ALU sees a defined
  // opcode; the illegal flag lets the exception logic act on it.
  always_comb begin
    op_next      = OP_ADD;
    illegal_next = 1'b0;
    case (aluop)
      2'b00: op_next = OP_ADD;
      2'b01: op_next = OP_SUB;
      2'b10: begin
        case (funct)
          6'b100000: op_next = OP_ADD;
          6'b100010: op_next = OP_SUB;
          6'b100100: op_next = OP_AND;
          6'b100101: op_next = OP_OR;
          6'b101010: op_next = OP_SLT;
          default:   illegal_next = 1'b1;
        endcase
      end
      default: illegal_next = 1'b1;
    endcase
  end

  // EX/MEM is the younger producer, so it takes priority; $zero never forwards.
  logic exmem_hit_a, memwb_hit_a, exmem_hit_b, memwb_hit_b;

  assign exmem_hit_a = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_addr);
  assign memwb_hit_a = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_addr);
  assign exmem_hit_b = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_addr);
  assign memwb_hit_b = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_addr);

  always_comb begin
    fwd_a = rs_data;
    if (exmem_hit_a)      fwd_a = exmem_res;
    else if (memwb_hit_a) fwd_a = memwb_res;
  end

  always_comb begin
    fwd_b = rt_data;
    if (exmem_hit_b)      fwd_b = exmem_res;
    else if (memwb_hit_b) fwd_b = memwb_res;
  end

  assign imm_ext = {{(WIDTH-16){imm16[15]}}, imm16};
  assign b_next  = alusrc ? imm_ext : fwd_b;

  // Held operands are deliberately not re-resolved during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      alu_opcode <= OP_AND;
      alu_a      <= '0;
      alu_b      <= '0;
      store_data <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      alu_opcode <= OP_AND;
      alu_a      <= '0;
      alu_b      <= '0;
      store_data <= '0;
    end else if (!stall) begin
      out_valid  <= 1'b1;
      illegal    <= illegal_next;
      alu_opcode <= op_next;
      alu_a      <= fwd_a;
      alu_b      <= b_next;
      store_data <= fwd_b;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int WIDTH      = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  stall, flush, in_valid;
  logic [1:0]            aluop;
  logic [5:0]            funct;
  logic                  alusrc;
  logic [REG_ADDR_W-1:0] rs_addr, rt_addr;
  logic [WIDTH-1:0]      rs_data, rt_data;
  logic [15:0]           imm16;
  logic                  exmem_regwrite;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [WIDTH-1:0]      exmem_res;
  logic                  memwb_regwrite;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [WIDTH-1:0]      memwb_res;
  logic                  out_valid;
  logic [2:0]            alu_opcode;
  logic [WIDTH-1:0]      alu_a, alu_b, store_data;
  logic                  illegal;

  id_ex_stage #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .aluop(aluop), .funct(funct), .alusrc(alusrc),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_res(memwb_res),
    .out_valid(out_valid), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .store_data(store_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, got, want);
    end
  endtask

  task automatic push(input string tag, input logic v, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] sd, input logic ill);
    exp_t e;
    e.tag = tag; e.valid = v; e.op = op; e.a = a; e.b = b; e.sd = sd; e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    tests--;
    e = exp_q.pop_front();
    chk(e.tag, "out_valid",  {31'b0, out_valid}, {31'b0, e.valid});
    chk(e.tag, "alu_opcode", {29'b0, alu_opcode}, {29'b0, e.op});
    chk(e.tag, "alu_a",      alu_a, e.a);
    chk(e.tag, "alu_b",      alu_b, e.b);
    chk(e.tag, "store_data", store_data, e.sd);
    chk(e.tag, "illegal",    {31'b0, illegal}, {31'b0, e.ill});
  endtask

  // Inputs are changed just after a rising edge, outputs sampled 1 time unit
  // after the edge that captured them.
  task automatic cycle();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic src, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [31:0] da, input logic [31:0] db,
                       input logic [15:0] imm);
    in_valid = v; aluop = op; funct = fn; alusrc = src;
    rs_addr = ra; rt_addr = rb; rs_data = da; rt_data = db; imm16 = imm;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                     input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_regwrite = ew; exmem_rd = erd; exmem_res = eres;
    memwb_regwrite = mw; memwb_rd = mrd; memwb_res = mres;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'b00, 6'h00, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0);
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #3;
    push("reset", 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    drive(1'b1, 2'b10, 6'b100100, 1'b0, 5'd1, 5'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0);
    push("r_and", 1'b1, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0FF00FF0, 1'b0);
    cycle();

    drive(1'b1, 2'b00, 6'h00, 1'b1, 5'd1, 5'd2, 32'h00000010, 32'h12345678, 16'hFFFC);
    push("imm_sext", 1'b1, 3'b010, 32'h00000010, 32'hFFFFFFFC, 32'h12345678, 1'b0);
    cycle();

    drive(1'b1, 2'b10, 6'b100000, 1'b0, 5'd7, 5'd3, 32'h11111111, 32'h22222222, 16'h0);
    fwd(1'b1, 5'd7, 32'hAAAA0001, 1'b1, 5'd7, 32'hBBBB0002);
    push("fwd_exmem_prio", 1'b1, 3'b010, 32'hAAAA0001, 32'h22222222, 32'h22222222, 1'b0);
    cycle();

    exmem_regwrite = 1'b0;
    push("fwd_memwb", 1'b1, 3'b010, 32'hBBBB0002, 32'h22222222, 32'h22222222, 1'b0);
    cycle();

    rs_addr = 5'd0; rt_addr = 5'd0;
    fwd(1'b1, 5'd0, 32'hAAAA0001, 1'b1, 5'd0, 32'hBBBB0002);
    push("fwd_r0", 1'b1, 3'b010, 32'h11111111, 32'h22222222, 32'h22222222, 1'b0);
    cycle();

    drive(1'b1, 2'b00, 6'h00, 1'b1, 5'd0, 5'd5, 32'h0000ABCD, 32'h33333333, 16'h7FFF);
    fwd(1'b1, 5'd5, 32'hAAAA0001, 1'b1, 5'd5, 32'hBBBB0002);
    push("fwd_rt_store", 1'b1, 3'b010, 32'h0000ABCD, 32'h00007FFF, 32'hAAAA0001, 1'b0);
    cycle();

    drive(1'b1, 2'b10, 6'b100010, 1'b0, 5'd4, 5'd5, 32'h00000009, 32'h44444444, 16'h0);
    fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hCAFE0005);
    push("r_sub_memwb_b", 1'b1, 3'b110, 32'h00000009, 32'hCAFE0005, 32'hCAFE0005, 1'b0);
    cycle();

    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 2'b10, 6'b100101, 1'b0, 5'd4, 5'd5, 32'h0000FF00, 32'h000000FF, 16'h0);
    push("r_or", 1'b1, 3'b001, 32'h0000FF00, 32'h000000FF, 32'h000000FF, 1'b0);
    cycle();

    drive(1'b1, 2'b01, 6'h3F, 1'b0, 5'd4, 5'd5, 32'h00000003, 32'h00000003, 16'h0);
    push("branch_sub", 1'b1, 3'b110, 32'h00000003, 32'h00000003, 32'h00000003, 1'b0);
    cycle();

    drive(1'b1, 2'b10, 6'b101010, 1'b0, 5'd8, 5'd9, 32'h00000005, 32'h00000009, 16'h0);
    push("slt", 1'b1, 3'b111, 32'h00000005, 32'h00000009, 32'h00000009, 1'b0);
    cycle();

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 2'b00, 6'h00, 1'b1, 5'd8, 5'd9, 32'hDEAD0000 + i, 32'hBEEF0000 + i, 16'h8000);
      fwd(1'b1, 5'd8, 32'h5555AAAA, 1'b1, 5'd9, 32'h6666BBBB);
      push("stall_hold", 1'b1, 3'b111, 32'h00000005, 32'h00000009, 32'h00000009, 1'b0);
      cycle();
    end

    flush = 1'b1;
    push("stall_flush", 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    cycle();
    stall = 1'b0; flush = 1'b0;
    fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    drive(1'b1, 2'b10, 6'b000000, 1'b0, 5'd1, 5'd2, 32'h00000077, 32'h00000088, 16'h0);
    push("illegal_funct", 1'b1, 3'b010, 32'h00000077, 32'h00000088, 32'h00000088, 1'b1);
    cycle();

    drive(1'b1, 2'b11, 6'b100100, 1'b0, 5'd1, 5'd2, 32'h00000099, 32'h000000AA, 16'h0);
    push("illegal_aluop", 1'b1, 3'b010, 32'h00000099, 32'h000000AA, 32'h000000AA, 1'b1);
    cycle();

    in_valid = 1'b0;
    push("bubble", 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    cycle();

    drive(1'b1, 2'b10, 6'b100000, 1'b0, 5'd1, 5'd2, 32'h01010101, 32'h02020202, 16'h0);
    push("pre_reset", 1'b1, 3'b010, 32'h01010101, 32'h02020202, 32'h02020202, 1'b0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    push("async_reset", 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 2'b10, 6'b100010, 1'b0, 5'd1, 5'd2, 32'h00000010, 32'h00000004, 16'h0);
    push("post_reset", 1'b1, 3'b110, 32'h00000010, 32'h00000004, 32'h00000004, 1'b0);
    cycle();

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
